mmio_bus_decoder: RTL and testbench

//  Parametrised memory-mapped bus decoder between the RISC-V core's data port and its

---
 rtl/mmio_bus_decoder.sv | 147 ++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_decoder.sv
// Routes each latched core data-port request to data memory or one peripheral window,
// waits for that target's ready (bounded by TIMEOUT) and returns one ack/rdata/err beat.
module mmio_bus_decoder #(
  parameter int                          N_PERIPH    = 2,
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter logic [N_PERIPH*ADDR_W-1:0]  PERIPH_BASE = {32'd64, 32'd60},
  parameter logic [N_PERIPH*ADDR_W-1:0]  PERIPH_MASK = {2{32'hFFFFFFFF}},
  parameter int                          TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic                           cpu_ack,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_err,
  output logic [ADDR_W-1:0]              bus_addr,
  output logic [DATA_W-1:0]              bus_wdata,
  output logic                           mem_sel,
  output logic                           mem_we,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ready,
  output logic [N_PERIPH-1:0]            periph_sel,
  output logic                           periph_we,
  input  logic [N_PERIPH*DATA_W-1:0]     periph_rdata,
  input  logic [N_PERIPH-1:0]            periph_ready,
  output logic [$clog2(N_PERIPH+1)-1:0]  rd_sel
);

  localparam int RS_W  = $clog2(N_PERIPH + 1);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [RS_W-1:0]       rd_sel_q;
  logic [ADDR_W-1:0]     bus_addr_q;
  logic [DATA_W-1:0]     bus_wdata_q;
  logic                  cpu_ack_q;
  logic [DATA_W-1:0]     cpu_rdata_q;
  logic                  cpu_err_q;
  logic                  mem_sel_q;
  logic                  mem_we_q;
  logic [N_PERIPH-1:0]   periph_sel_q;
  logic                  periph_we_q;

  logic [N_PERIPH-1:0]   hit;
  logic [RS_W-1:0]       rd_sel_d;
  logic [N_PERIPH-1:0]   periph_sel_d;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;

  for (genvar gi = 0; gi < N_PERIPH; gi++) begin : g_win
    assign hit[gi] = (cpu_addr & PERIPH_MASK[gi*ADDR_W +: ADDR_W]) ==
                     (PERIPH_BASE[gi*ADDR_W +: ADDR_W] & PERIPH_MASK[gi*ADDR_W +: ADDR_W]);
    assign periph_sel_d[gi] = (rd_sel_d == RS_W'(gi + 1));
  end

  // Scan from the top window down so the lowest hitting window overrides the rest.
  always_comb begin
    rd_sel_d = '0;
    for (int k = N_PERIPH - 1; k >= 0; k--) begin
      if (hit[k]) rd_sel_d = RS_W'(k + 1);
    end
  end

  always_comb begin
    sel_ready = mem_ready;
    sel_rdata = mem_rdata;
    for (int k = 0; k < N_PERIPH; k++) begin
      if (rd_sel_q == RS_W'(k + 1)) begin
        sel_ready = periph_ready[k];
        sel_rdata = periph_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      rd_sel_q     <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_err_q    <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      periph_sel_q <= '0;
      periph_we_q  <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            bus_addr_q   <= cpu_addr;
            bus_wdata_q  <= cpu_wdata;
            we_q         <= cpu_we;
            rd_sel_q     <= rd_sel_d;
            cnt_q        <= '0;
            mem_sel_q    <= (rd_sel_d == '0);
            mem_we_q     <= cpu_we && (rd_sel_d == '0);
            periph_sel_q <= periph_sel_d;
            periph_we_q  <= cpu_we && (rd_sel_d != '0);
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (sel_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Writes and timeouts both return zero data.
            cpu_rdata_q  <= (sel_ready && !we_q) ? sel_rdata : '0;
            cpu_err_q    <= !sel_ready;
            cpu_ack_q    <= 1'b1;
            mem_sel_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            periph_sel_q <= '0;
            periph_we_q  <= 1'b0;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_err    = cpu_err_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign mem_sel    = mem_sel_q;
  assign mem_we     = mem_we_q;
  assign periph_sel = periph_sel_q;
  assign periph_we  = periph_we_q;
  assign rd_sel     = rd_sel_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed bench for mmio_bus_decoder: default map instance d1, overlapping-window instance d2.
module tb_mmio_bus_decoder;
  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [63:0] periph_rdata;
  logic [1:0]  periph_ready;

  logic        ack1, err1, msel1, mwe1, pwe1;
  logic [31:0] rdata1, baddr1, bwdata1;
  logic [1:0]  psel1, rsel1;
  logic        ack2, err2, msel2, mwe2, pwe2;
  logic [31:0] rdata2, baddr2, bwdata2;
  logic [1:0]  psel2, rsel2;

  int total = 0;
  int bad   = 0;

  mmio_bus_decoder d1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(ack1), .cpu_rdata(rdata1), .cpu_err(err1),
    .bus_addr(baddr1), .bus_wdata(bwdata1), .mem_sel(msel1), .mem_we(mwe1),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .periph_sel(psel1), .periph_we(pwe1),
    .periph_rdata(periph_rdata), .periph_ready(periph_ready), .rd_sel(rsel1)
  );

  mmio_bus_decoder #(.PERIPH_BASE({32'd60, 32'd60})) d2 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(ack2), .cpu_rdata(rdata2), .cpu_err(err2),
    .bus_addr(baddr2), .bus_wdata(bwdata2), .mem_sel(msel2), .mem_we(mwe2),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .periph_sel(psel2), .periph_we(pwe2),
    .periph_rdata(periph_rdata), .periph_ready(periph_ready), .rd_sel(rsel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0; periph_rdata = '0; periph_ready = '0;
    #2;
    total++;
    if ({ack1, err1, msel1, mwe1, pwe1, psel1, rsel1} !== 9'b0 || rdata1 !== 32'h0 || baddr1 !== 32'h0) begin
      bad++; $display("FAIL reset_outputs ack=%b sel=%b psel=%b rdata=%h baddr=%h exp all zero", ack1, msel1, psel1, rdata1, baddr1);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    total++;
    if (ack1 !== 1'b0) begin bad++; $display("FAIL reset_idle_ack got=%b exp=0", ack1); end
  endtask

  task automatic test_periph_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd60; cpu_wdata = 32'hA5; periph_ready = 2'b01;
    periph_rdata = {32'h2222_2222, 32'h1111_1111};
    step();
    cpu_req = 1'b0;
    total++;
    if (psel1 !== 2'b01 || pwe1 !== 1'b1 || msel1 !== 1'b0 || mwe1 !== 1'b0 || ack1 !== 1'b0) begin
      bad++; $display("FAIL wr_access psel=%b pwe=%b msel=%b mwe=%b ack=%b exp psel=01 pwe=1 msel=0 mwe=0 ack=0", psel1, pwe1, msel1, mwe1, ack1);
    end
    total++;
    if (bwdata1 !== 32'hA5 || baddr1 !== 32'd60) begin
      bad++; $display("FAIL wr_bus baddr=%h bwdata=%h exp 3c/a5", baddr1, bwdata1);
    end
    step();
    total++;
    if (ack1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h0 || psel1 !== 2'b00 || pwe1 !== 1'b0 || msel1 !== 1'b0) begin
      bad++; $display("FAIL wr_resp ack=%b err=%b rdata=%h psel=%b pwe=%b msel=%b exp ack=1 err=0 rdata=0 sel=0", ack1, err1, rdata1, psel1, pwe1, msel1);
    end
    step();
    total++;
    if (ack1 !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0", ack1); end
  endtask

  task automatic test_mem_read_wait();
    int sel_cycles = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    mem_ready = 1'b0; periph_ready = 2'b11;
    step();
    cpu_req = 1'b0; cpu_addr = 32'd60;
    if (msel1) sel_cycles++;
    total++;
    if (rsel1 !== 2'd0 || psel1 !== 2'b00 || mwe1 !== 1'b0) begin
      bad++; $display("FAIL rd_decode rd_sel=%0d psel=%b mwe=%b exp 0/00/0", rsel1, psel1, mwe1);
    end
    step();
    if (msel1) sel_cycles++;
    step();
    if (msel1) sel_cycles++;
    mem_ready = 1'b1;
    total++;
    if (ack1 !== 1'b0 || baddr1 !== 32'h100) begin
      bad++; $display("FAIL rd_wait ack=%b baddr=%h exp ack=0 baddr=100", ack1, baddr1);
    end
    step();
    if (msel1) sel_cycles++;
    mem_ready = 1'b0; periph_ready = 2'b00;
    total++;
    if (ack1 !== 1'b1 || rdata1 !== 32'hDEADBEEF || err1 !== 1'b0) begin
      bad++; $display("FAIL rd_resp ack=%b rdata=%h err=%b exp 1/deadbeef/0", ack1, rdata1, err1);
    end
    total++;
    if (sel_cycles != 3) begin bad++; $display("FAIL rd_sel_cycles got=%0d exp=3", sel_cycles); end
    step();
    total++;
    if (ack1 !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_hold ack=%b rdata=%h exp 0/deadbeef", ack1, rdata1);
    end
  endtask

  task automatic test_timeout();
    int sel_cycles = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd64; periph_ready = 2'b00; mem_ready = 1'b0;
    step();
    cpu_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack1) break;
      if (psel1 === 2'b10) sel_cycles++;
      step();
    end
    total++;
    if (sel_cycles != 16) begin bad++; $display("FAIL to_sel_cycles got=%0d exp=16", sel_cycles); end
    total++;
    if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0 || psel1 !== 2'b00 || msel1 !== 1'b0) begin
      bad++; $display("FAIL to_resp ack=%b err=%b rdata=%h psel=%b msel=%b exp 1/1/0/00/0", ack1, err1, rdata1, psel1, msel1);
    end
    step();
  endtask

  task automatic test_overlap();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd60; cpu_wdata = 32'h77; periph_ready = 2'b01;
    step();
    cpu_req = 1'b0;
    total++;
    if (rsel2 !== 2'd1 || psel2 !== 2'b01 || msel2 !== 1'b0) begin
      bad++; $display("FAIL overlap_sel rd_sel=%0d psel=%b msel=%b exp 1/01/0", rsel2, psel2, msel2);
    end
    step();
    total++;
    if (ack2 !== 1'b1 || err2 !== 1'b0) begin bad++; $display("FAIL overlap_resp ack=%b err=%b exp 1/0", ack2, err2); end
    step();
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_ready = 1'b0; periph_ready = 2'b00;
    step();
    cpu_req = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (msel1 !== 1'b0 || baddr1 !== 32'h0 || ack1 !== 1'b0 || rdata1 !== 32'h0) begin
      bad++; $display("FAIL async_reset msel=%b baddr=%h ack=%b rdata=%h exp all zero", msel1, baddr1, ack1, rdata1);
    end
    mem_ready = 1'b1;
    step();
    total++;
    if (ack1 !== 1'b0 || msel1 !== 1'b0) begin bad++; $display("FAIL reset_no_ack ack=%b msel=%b exp 0/0", ack1, msel1); end
    rst_n = 1'b1; mem_ready = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd60; cpu_wdata = 32'h5A; periph_ready = 2'b01;
    step();
    cpu_req = 1'b0;
    step();
    total++;
    if (ack1 !== 1'b1 || err1 !== 1'b0) begin bad++; $display("FAIL post_reset_xfer ack=%b err=%b exp 1/0", ack1, err1); end
    step();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; mem_rdata = 32'h12345678;
    mem_ready = 1'b1; periph_ready = 2'b01;
    step();
    step();
    total++;
    if (ack1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      bad++; $display("FAIL b2b_first ack=%b rdata=%h exp 1/12345678", ack1, rdata1);
    end
    cpu_addr = 32'd60; cpu_we = 1'b1; cpu_wdata = 32'hC3;
    step();
    total++;
    if (ack1 !== 1'b0 || psel1 !== 2'b00) begin bad++; $display("FAIL b2b_idle ack=%b psel=%b exp 0/00", ack1, psel1); end
    step();
    cpu_req = 1'b0;
    total++;
    if (psel1 !== 2'b01 || rsel1 !== 2'd1 || pwe1 !== 1'b1 || msel1 !== 1'b0) begin
      bad++; $display("FAIL b2b_second psel=%b rd_sel=%0d pwe=%b msel=%b exp 01/1/1/0", psel1, rsel1, pwe1, msel1);
    end
    step();
    total++;
    if (ack1 !== 1'b1 || rdata1 !== 32'h0 || err1 !== 1'b0) begin
      bad++; $display("FAIL b2b_second_ack ack=%b rdata=%h err=%b exp 1/0/0", ack1, rdata1, err1);
    end
    mem_ready = 1'b0; periph_ready = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_periph_write();
    test_mem_read_wait();
    test_timeout();
    test_overlap();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
